// File: rtl/pwm_segment_sequencer.sv
// pwm_segment_sequencer
// ---------------------------------------------------------------------------
// Steps the duty threshold of a PWM datapath through a programmed list of
// (threshold, hold) segments. Each segment lasts hold+1 PWM periods, where a
// period ends at each period_boundary_i pulse. Playback is one-shot or looped.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wr_en_i/wr_addr_i    segment table write port (any state)
//   wr_threshold_i       threshold field of the written segment
//   wr_hold_i            hold field of the written segment
//   last_idx_i           index of final segment, latched on start
//   loop_i               wrap to segment 0 after last segment (sampled live)
//   start_i / stop_i     start playback (IDLE only) / abort (highest priority)
//   period_boundary_i    one-cycle pulse at each PWM period end
//   threshold_o          threshold driven to the PWM datapath
//   active_o             high while loading or running a segment
//   seg_idx_o            current segment index
//   done_o               one-cycle pulse when one-shot playback completes
// ---------------------------------------------------------------------------
module pwm_segment_sequencer #(
  parameter int Resolution = 16,
  parameter int AddrWidth  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [AddrWidth-1:0]  wr_addr_i,
  input  logic [Resolution-1:0] wr_threshold_i,
  input  logic [Resolution-1:0] wr_hold_i,
  input  logic [AddrWidth-1:0]  last_idx_i,
  input  logic                  loop_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  period_boundary_i,
  output logic [Resolution-1:0] threshold_o,
  output logic                  active_o,
  output logic [AddrWidth-1:0]  seg_idx_o,
  output logic                  done_o
);

  localparam int Depth = 2 ** AddrWidth;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [AddrWidth-1:0]  seg_idx_q,   seg_idx_d;
  logic [AddrWidth-1:0]  last_idx_q,  last_idx_d;
  logic [Resolution-1:0] hold_cnt_q,  hold_cnt_d;
  logic [Resolution-1:0] threshold_q, threshold_d;
  logic                  active_q,    active_d;
  logic                  done_q,      done_d;

  // Segment table: deliberately not reset, contents survive rst_ni.
  logic [Resolution-1:0] tbl_threshold_mem [Depth];
  logic [Resolution-1:0] tbl_hold_mem      [Depth];
  logic [Resolution-1:0] rd_threshold;
  logic [Resolution-1:0] rd_hold;

  // Segment table write port, usable in every state.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tbl_threshold_mem[wr_addr_i] <= wr_threshold_i;
      tbl_hold_mem[wr_addr_i]      <= wr_hold_i;
    end
  end

  // Asynchronous read; a same-cycle write lands at the edge, so LOAD sees
  // the old entry (read-before-write).
  assign rd_threshold = tbl_threshold_mem[seg_idx_q];
  assign rd_hold      = tbl_hold_mem[seg_idx_q];

  // Next-state and next-output logic of the playback FSM.
  always_comb begin
    state_d     = state_q;
    seg_idx_d   = seg_idx_q;
    last_idx_d  = last_idx_q;
    hold_cnt_d  = hold_cnt_q;
    threshold_d = threshold_q;
    done_d      = 1'b0;

    if (stop_i) begin
      // Abort wins over start, boundaries and the DONE pulse.
      state_d     = ST_IDLE;
      seg_idx_d   = '0;
      threshold_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          threshold_d = '0;
          if (start_i) begin
            seg_idx_d  = '0;
            last_idx_d = last_idx_i;
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_LOAD: begin
          // Boundaries arriving here are intentionally ignored.
          threshold_d = rd_threshold;
          hold_cnt_d  = rd_hold;
          state_d     = ST_RUN;
        end

        ST_RUN: begin
          if (period_boundary_i) begin
            if (hold_cnt_q != '0) begin
              // Decrement only while nonzero, so hold = all-ones never wraps.
              hold_cnt_d = hold_cnt_q - Resolution'(1);
            end else if (seg_idx_q != last_idx_q) begin
              seg_idx_d = seg_idx_q + AddrWidth'(1);
              state_d   = ST_LOAD;
            end else if (loop_i) begin
              seg_idx_d = '0;
              state_d   = ST_LOAD;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          threshold_d = '0;
          seg_idx_d   = '0;
          state_d     = ST_IDLE;
        end

        default: begin
          state_d     = ST_IDLE;
          seg_idx_d   = '0;
          threshold_d = '0;
        end
      endcase
    end

    active_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      seg_idx_q   <= '0;
      last_idx_q  <= '0;
      hold_cnt_q  <= '0;
      threshold_q <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_idx_q   <= seg_idx_d;
      last_idx_q  <= last_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      threshold_q <= threshold_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign threshold_o = threshold_q;
  assign active_o    = active_q;
  assign seg_idx_o   = seg_idx_q;
  // The registered pulse is masked by a stop arriving during the DONE cycle.
  assign done_o      = done_q & ~stop_i;

endmodule
